// File: rtl/fcvt_s_w_issue.sv
// Issue stage for fcvt.s.w / fcvt.s.wu in front of an unsigned int-to-float converter.
// Optional FCVT_ZERO_BYPASS_EN: a zero source is answered directly, without using the converter.
module fcvt_s_w_issue #(
  parameter int unsigned TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_a_i,
  input  logic             req_signed_i,
  input  logic [2:0]       req_rm_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [31:0]      cvt_a_o,
  output logic [2:0]       cvt_rm_o,
  output logic             cvt_rst_o,
  input  logic [31:0]      cvt_z_i,
  input  logic             cvt_stb_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_data_o,
  output logic             resp_nx_o,
  output logic             resp_err_o,
  output logic [TAG_W-1:0] resp_tag_o
);

  localparam int unsigned     CntW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [31:0]      cvt_a_q;
  logic [2:0]       cvt_rm_q;
  logic             cvt_rst_q;
  logic             neg_q;
  logic             nx_q;
  logic             resp_valid_q;
  logic [31:0]      resp_data_q;
  logic             resp_nx_q;
  logic             resp_err_q;
  logic [TAG_W-1:0] resp_tag_q;

  logic        neg;
  logic        nx;
  logic [31:0] mag;
  logic [2:0]  rm_eff;

  always_comb begin
    neg    = req_signed_i & req_a_i[31];
    mag    = neg ? (~req_a_i + 32'd1) : req_a_i;
    rm_eff = req_rm_i;
    // The converter sees a positive magnitude, so directed roundings flip for negatives.
    if (neg && (req_rm_i == 3'b010)) begin
      rm_eff = 3'b011;
    end else if (neg && (req_rm_i == 3'b011)) begin
      rm_eff = 3'b010;
    end
    // Bit j is discarded iff some bit at j+24 or above is set (leading one at p >= j+24).
    nx = 1'b0;
    for (int j = 0; j < 8; j++) begin
      nx = nx | (mag[j] & (|(mag >> (j + 24))));
    end
  end

  assign req_ready_o = (state_q == StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cvt_a_q      <= '0;
      cvt_rm_q     <= '0;
      cvt_rst_q    <= 1'b1;
      neg_q        <= 1'b0;
      nx_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_nx_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_tag_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            cvt_a_q    <= mag;
            cvt_rm_q   <= rm_eff;
            neg_q      <= neg;
            nx_q       <= nx;
            resp_tag_q <= req_tag_i;
`ifdef FCVT_ZERO_BYPASS_EN
            if (req_a_i == 32'd0) begin
              resp_data_q  <= '0;
              resp_nx_q    <= 1'b0;
              resp_err_q   <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              state_q <= StLaunch;
            end
`else
            state_q <= StLaunch;
`endif
          end
        end
        StLaunch: begin
          cvt_rst_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= StWait;
        end
        StWait: begin
          if (cvt_stb_i) begin
            resp_data_q  <= {cvt_z_i[31] | neg_q, cvt_z_i[30:0]};
            resp_nx_q    <= nx_q;
            resp_err_q   <= 1'b0;
            cvt_rst_q    <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else if (cnt_q == CntMax) begin
            resp_data_q  <= 32'h7FC0_0000;
            resp_nx_q    <= 1'b0;
            resp_err_q   <= 1'b1;
            cvt_rst_q    <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cvt_a_o      = cvt_a_q;
  assign cvt_rm_o     = cvt_rm_q;
  assign cvt_rst_o    = cvt_rst_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_nx_o    = resp_nx_q;
  assign resp_err_o   = resp_err_q;
  assign resp_tag_o   = resp_tag_q;

endmodule

// File: doc/fcvt_s_w_issue.md
Name: fcvt_s_w_issue

Overview:
- Issue/control stage placed directly upstream of the unsigned int-to-float converter.
- Serves the FPU dispatch for fcvt.s.w and fcvt.s.wu through a valid/ready request interface.
- For signed sources it takes the magnitude and drives the converter, then waits for the converter strobe.
- Applies the sign, computes the NX flag, and returns the result on a valid/ready response interface.

Parameters:
TAG_W, 5, width of destination-register tag carried request to response
TIMEOUT_CYCLES, 64, cycles in WAIT without converter strobe before error return

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_a  input  32  integer source (rs1)
req_signed  input  1  1 = fcvt.s.w (two's complement), 0 = fcvt.s.wu
req_rm  input  3  RISC-V rounding mode, already resolved (no DYN)
req_tag  input  TAG_W  destination tag
cvt_a  output  32  magnitude to converter input_a
cvt_rm  output  3  rounding mode to converter rm
cvt_rst  output  1  converter synchronous active-high reset/start hold
cvt_z  input  32  converter output_z
cvt_stb  input  1  converter output_z_stb
resp_valid  output  1  response valid
resp_ready  input  1  response accepted when resp_valid & resp_ready
resp_data  output  32  IEEE-754 single result
resp_nx  output  1  inexact flag
resp_err  output  1  converter timeout; resp_data forced 0x7FC00000
resp_tag  output  TAG_W  tag of the request

Behaviour:
- Reset (rst_n=0, async): state=IDLE; cvt_rst=1; cvt_a=0; cvt_rm=0; resp_valid=0; resp_data=0; resp_nx=0; resp_err=0; resp_tag=0; timeout counter=0.
- req_ready = (state==IDLE), combinational from state; one operation in flight at a time.
- Capture on request fire in IDLE:
  - neg = req_signed & req_a[31].
  - mag = neg ? (~req_a + 1) : req_a, 32-bit; 0x80000000 stays 0x80000000.
  - cvt_a <= mag.
  - cvt_rm <= req_rm, except when neg: RDN(3'b010) <-> RUP(3'b011) swapped.
  - neg and tag registered.
  - NX computed from mag: p = index of leading one; nx = (p>23) & (mag bits [p-24:0] != 0); nx=0 for mag=0.
  - Next state LAUNCH.
- LAUNCH (1 cycle): cvt_rst <= 0; timeout counter cleared; next state WAIT.
- WAIT: cvt_a/cvt_rm held stable; counter increments each cycle.
  - On cvt_stb=1: resp_data <= {cvt_z[31] | neg, cvt_z[30:0]}; resp_nx <= nx; resp_err <= 0; cvt_rst <= 1; resp_valid <= 1; next state RESP.
  - Counter reaching TIMEOUT_CYCLES-1 without cvt_stb: resp_err <= 1; resp_data <= 0x7FC00000; resp_nx <= 0; cvt_rst <= 1; resp_valid <= 1; next state RESP.
  - cvt_stb and timeout in the same cycle: the strobe wins.
- cvt_stb is ignored outside WAIT.
- RESP: all resp_* held stable while resp_ready=0. On resp_ready=1: resp_valid <= 0; next state IDLE. No request accepted in the same cycle (req_ready is already 0 in RESP).
- Zero source (when FCVT_ZERO_BYPASS_EN is not defined): converter result 0x00000000; sign never set (neg=0 for 0).
- Latency fire -> resp_valid is bounded by converter normalisation: at most 1 + 1 + 32 + 3 cycles, always below TIMEOUT_CYCLES at default.
- Reset asserted mid-operation: immediate return to reset values, including cvt_rst=1, which aborts the converter; in-flight request dropped without response.

Optional Feature:
- FCVT_ZERO_BYPASS_EN defined: a request with req_a==0 skips LAUNCH/WAIT. IDLE goes directly to RESP with resp_valid=1 the cycle after fire, resp_data=0x00000000, resp_nx=0, resp_err=0; cvt_rst stays 1 throughout.
- Not defined: zero goes through the converter like any other value.

Test Plan:
- Unsigned req_a=0x00000001, rm=RNE -> resp_data=0x3F800000, nx=0, err=0, resp_tag echoes req_tag.
- Signed req_a=0xFFFFFFFF (-1) -> resp_data=0xBF800000, nx=0.
- Signed req_a=0x80000000 -> cvt_a=0x80000000, resp_data=0xCF000000, nx=0.
- Unsigned req_a=0x01000001, rm=RNE -> resp_data=0x4B800000, nx=1.
- Rounding-mode swap: signed req_a=0xFEFFFFFF with rm=RDN -> cvt_rm=RUP observed, nx=1.
- Unsigned req_a=0xFFFFFFFF, rm=RNE -> 0x4F800000, nx=1.
- Backpressure and stall:
  - Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0.
  - Tie cvt_stb=0 -> resp_err=1, data 0x7FC00000 after TIMEOUT_CYCLES.
  - Assert rst_n=0 mid-WAIT -> all outputs at reset values in the same cycle, cvt_rst=1.
